mem_bus_ctrl: RTL and testbench

//  CPU-side memory access sequencer. Sits directly upstream of the dual-port pipelined

---
 rtl/mem_bus_ctrl_if.sv | 33 +++
 rtl/mem_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// CPU request/ack and memory-port bundle for mem_bus_ctrl.
// Modport master is the requester/memory side; modport slave is the sequencer.
interface mem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic [ADDR_W-1:0] mem_addr_rd;
    logic [DATA_W-1:0] mem_q;
    logic [ADDR_W-1:0] mem_addr_wr;
    logic [DATA_W-1:0] mem_data_wr;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_qw;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q, mem_qw,
        input  cpu_ready, cpu_ack, cpu_rdata, cpu_err,
        input  mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wren
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q, mem_qw,
        output cpu_ready, cpu_ack, cpu_rdata, cpu_err,
        output mem_addr_rd, mem_addr_wr, mem_data_wr, mem_wren
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// CPU-side access sequencer for a dual-port pipelined memory: one request at a time,
// read data or write-verify result returned with a one-cycle ack.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 4,
    parameter bit          VERIFY = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_bus_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] WR      = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [3:0] RD_CNT = 4'(RD_LAT);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT);

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
    logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
    logic [DATA_W-1:0] data_wr_q, data_wr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        wren_d    = 1'b0;
        rdata_d   = rdata_q;
        addr_rd_d = addr_rd_q;
        addr_wr_d = addr_wr_q;
        data_wr_d = data_wr_q;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_we) begin
                        addr_wr_d = bus.cpu_addr;
                        data_wr_d = bus.cpu_wdata;
                        wren_d    = 1'b1;
                        state_d   = WR;
                    end else begin
                        addr_rd_d = bus.cpu_addr;
                        cnt_d     = RD_CNT;
                        state_d   = RD_WAIT;
                    end
                end
            end
            // Read count is loaded on the accept edge itself, so it runs down to zero
            // to land the capture on E0+RD_LAT+1.
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = bus.mem_q;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WR: begin
                if (VERIFY) begin
                    cnt_d   = WR_CNT;
                    state_d = WR_WAIT;
                end else begin
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            // Write count is loaded one edge after accept, so it finishes on reaching 1.
            WR_WAIT: begin
                if (cnt_q == 4'd1) begin
                    err_d   = (bus.mem_qw != data_wr_q);
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wren_q    <= 1'b0;
            rdata_q   <= '0;
            addr_rd_q <= '0;
            addr_wr_q <= '0;
            data_wr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            wren_q    <= wren_d;
            rdata_q   <= rdata_d;
            addr_rd_q <= addr_rd_d;
            addr_wr_q <= addr_wr_d;
            data_wr_q <= data_wr_d;
        end
    end

    assign bus.cpu_ready   = ready_q;
    assign bus.cpu_ack     = ack_q;
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_err     = err_q;
    assign bus.mem_addr_rd = addr_rd_q;
    assign bus.mem_addr_wr = addr_wr_q;
    assign bus.mem_data_wr = data_wr_q;
    assign bus.mem_wren    = wren_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: three builds (default, VERIFY=1, latency-1 VERIFY=1)
// sharing one memory model and one set of request fields, each with its own req strobe.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  req = 3'b000;
    logic        we_r = 1'b0;
    logic [15:0] addr_r = 16'h0;
    logic [7:0]  wdata_r = 8'h0;
    logic        qw_force = 1'b0;
    logic [7:0]  qw_val = 8'h0;
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;

    logic        ready_s [3];
    logic        ack_s [3];
    logic        err_s [3];
    logic        wren_s [3];
    logic [7:0]  rdata_s [3];
    logic [15:0] addr_rd_s [3];
    logic [15:0] addr_wr_s [3];
    logic [7:0]  data_wr_s [3];

    logic [7:0]  mem [65536];
    logic [7:0]  rs1 [3];
    logic [7:0]  rs2 [3];
    logic [7:0]  wsh [3][4];

    int n_tests = 0;
    int n_fail = 0;

    mem_bus_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_conn
        assign bus[g].cpu_req   = req[g];
        assign bus[g].cpu_we    = we_r;
        assign bus[g].cpu_addr  = addr_r;
        assign bus[g].cpu_wdata = wdata_r;
        assign bus[g].mem_q     = (g == 2) ? rs1[g] : rs2[g];
        assign bus[g].mem_qw    = (g == 2) ? wsh[g][0] :
                                  (g == 1 && qw_force) ? qw_val : wsh[g][3];
        assign ready_s[g]   = bus[g].cpu_ready;
        assign ack_s[g]     = bus[g].cpu_ack;
        assign err_s[g]     = bus[g].cpu_err;
        assign wren_s[g]    = bus[g].mem_wren;
        assign rdata_s[g]   = bus[g].cpu_rdata;
        assign addr_rd_s[g] = bus[g].mem_addr_rd;
        assign addr_wr_s[g] = bus[g].mem_addr_wr;
        assign data_wr_s[g] = bus[g].mem_data_wr;
    end

    mem_bus_ctrl #(.VERIFY(1'b0)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
    mem_bus_ctrl #(.VERIFY(1'b1)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus[1]));
    mem_bus_ctrl #(.RD_LAT(1), .WR_LAT(1), .VERIFY(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus[2]));

    // Memory model: 2-stage read pipe (1-stage for build c), 4-deep write readback pipe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rs1[i] <= mem[addr_rd_s[i]];
            rs2[i] <= rs1[i];
            wsh[i][0] <= wren_s[i] ? data_wr_s[i] : mem[addr_wr_s[i]];
            for (int j = 1; j < 4; j++) wsh[i][j] <= wsh[i][j-1];
            if (wren_s[i]) mem[addr_wr_s[i]] <= data_wr_s[i];
        end
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Issues one request on build idx and reports edges-to-ack and wren-high cycles.
    task automatic issue(input int idx, input logic we, input logic [15:0] a,
                         input logic [7:0] d, output int lat, output logic [7:0] rd,
                         output logic er, output int wc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_s[idx] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        we_r = we;
        addr_r = a;
        wdata_r = d;
        req[idx] = 1'b1;
        @(negedge clk);
        req[idx] = 1'b0;
        lat = 0;
        wc = wren_s[idx] ? 1 : 0;
        while (!ack_s[idx] && lat < 20) begin
            @(negedge clk);
            lat++;
            if (wren_s[idx]) wc++;
        end
        if (!ack_s[idx]) lat = 99;
        rd = rdata_s[idx];
        er = err_s[idx];
    endtask

    task automatic test_reset();
        int late;
        @(negedge clk);
        n_tests++;
        if (ready_s[0] !== 1'b1 || ack_s[0] !== 1'b0 || err_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: ready=%b ack=%b err=%b want 1 0 0",
                     ready_s[0], ack_s[0], err_s[0]);
        end
        n_tests++;
        if (rdata_s[0] !== 8'h00 || wren_s[0] !== 1'b0 || addr_rd_s[0] !== 16'h0 ||
            addr_wr_s[0] !== 16'h0 || data_wr_s[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h wren=%b ard=%h awr=%h dwr=%h want all 0",
                     rdata_s[0], wren_s[0], addr_rd_s[0], addr_wr_s[0], data_wr_s[0]);
        end
        rst_n = 1'b1;
        // Reset dropped into RD_WAIT
        @(negedge clk);
        we_r = 1'b0;
        addr_r = 16'h0042;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ready_s[0] !== 1'b1 || ack_s[0] !== 1'b0 || wren_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: ready=%b ack=%b wren=%b want 1 0 0",
                     ready_s[0], ack_s[0], wren_s[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_s[0]) late++;
        end
        n_tests++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL reset_no_late_ack: acks=%0d want 0", late);
        end
        // Reset while the write strobe is high must drop it at once
        @(negedge clk);
        we_r = 1'b1;
        addr_r = 16'h0077;
        wdata_r = 8'h99;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        n_tests++;
        if (wren_s[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wren_after_accept: got %b want 1", wren_s[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (wren_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_wren: got %b want 0", wren_s[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        preload(16'h1234, 8'hA5);
        @(negedge clk);
        we_r = 1'b0;
        addr_r = 16'h1234;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        n_tests++;
        if (addr_rd_s[0] !== 16'h1234 || ready_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_e0: addr_rd=%h ready=%b want 1234 0",
                     addr_rd_s[0], ready_s[0]);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (ack_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_early_ack: ack=%b at E2 want 0", ack_s[0]);
        end
        @(negedge clk);
        n_tests++;
        if (ack_s[0] !== 1'b1 || rdata_s[0] !== 8'hA5 || wren_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_e3: ack=%b rdata=%h wren=%b want 1 a5 0",
                     ack_s[0], rdata_s[0], wren_s[0]);
        end
        @(negedge clk);
        n_tests++;
        if (ack_s[0] !== 1'b0 || ready_s[0] !== 1'b1 || rdata_s[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_e4: ack=%b ready=%b rdata=%h want 0 1 a5",
                     ack_s[0], ready_s[0], rdata_s[0]);
        end
    endtask

    task automatic test_write_read();
        int lat, wc;
        logic [7:0] rd;
        logic er;
        issue(0, 1'b1, 16'h0010, 8'h5A, lat, rd, er, wc);
        n_tests++;
        if (lat !== 1 || wc !== 1 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL write_v0: lat=%0d wren_cycles=%0d err=%b want 1 1 0", lat, wc, er);
        end
        issue(0, 1'b0, 16'h0010, 8'h00, lat, rd, er, wc);
        n_tests++;
        if (lat !== 3 || rd !== 8'h5A || wc !== 0) begin
            n_fail++;
            $display("FAIL raw_read: lat=%0d rdata=%h wren_cycles=%0d want 3 5a 0",
                     lat, rd, wc);
        end
    endtask

    task automatic test_verify();
        int lat, wc;
        logic [7:0] rd;
        logic er;
        issue(1, 1'b1, 16'h8000, 8'h3C, lat, rd, er, wc);
        n_tests++;
        if (lat !== 5 || er !== 1'b0 || wc !== 1) begin
            n_fail++;
            $display("FAIL verify_ok: lat=%0d err=%b wren_cycles=%0d want 5 0 1", lat, er, wc);
        end
        n_tests++;
        if (addr_wr_s[1] !== 16'h8000 || data_wr_s[1] !== 8'h3C) begin
            n_fail++;
            $display("FAIL verify_hold: awr=%h dwr=%h want 8000 3c",
                     addr_wr_s[1], data_wr_s[1]);
        end
        qw_force = 1'b1;
        qw_val = 8'h3D;
        issue(1, 1'b1, 16'h8000, 8'h3C, lat, rd, er, wc);
        qw_force = 1'b0;
        n_tests++;
        if (lat !== 5 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL verify_bad: lat=%0d err=%b want 5 1", lat, er);
        end
        @(negedge clk);
        n_tests++;
        if (err_s[1] !== 1'b0 || ack_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL verify_err_clear: err=%b ack=%b want 0 0", err_s[1], ack_s[1]);
        end
    endtask

    task automatic test_back_to_back();
        int acks, first, second, readies;
        acks = 0;
        first = -1;
        second = -1;
        readies = 0;
        @(negedge clk);
        while (!ready_s[0]) @(negedge clk);
        we_r = 1'b0;
        addr_r = 16'h1234;
        req[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack_s[0]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
                acks++;
            end
            if (ready_s[0]) readies++;
        end
        req[0] = 1'b0;
        n_tests++;
        if (acks !== 4 || first !== 3 || second !== 8) begin
            n_fail++;
            $display("FAIL b2b_acks: count=%0d first=%0d second=%0d want 4 3 8",
                     acks, first, second);
        end
        n_tests++;
        if (readies !== 4 || rdata_s[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL b2b_ready: ready_cycles=%0d rdata=%h want 4 a5",
                     readies, rdata_s[0]);
        end
    endtask

    task automatic test_boundaries();
        int lat, wc;
        logic [7:0] rd;
        logic er;
        issue(0, 1'b1, 16'hFFFF, 8'h11, lat, rd, er, wc);
        issue(0, 1'b1, 16'h0000, 8'h22, lat, rd, er, wc);
        n_tests++;
        if (addr_wr_s[0] !== 16'h0000 || data_wr_s[0] !== 8'h22) begin
            n_fail++;
            $display("FAIL bound_wr_hold: awr=%h dwr=%h want 0000 22",
                     addr_wr_s[0], data_wr_s[0]);
        end
        issue(0, 1'b0, 16'hFFFF, 8'h00, lat, rd, er, wc);
        n_tests++;
        if (lat !== 3 || rd !== 8'h11) begin
            n_fail++;
            $display("FAIL bound_ffff: lat=%0d rdata=%h want 3 11", lat, rd);
        end
        issue(0, 1'b0, 16'h0000, 8'h00, lat, rd, er, wc);
        n_tests++;
        if (lat !== 3 || rd !== 8'h22 || addr_rd_s[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL bound_0000: lat=%0d rdata=%h ard=%h want 3 22 0000",
                     lat, rd, addr_rd_s[0]);
        end
        issue(2, 1'b0, 16'h1234, 8'h00, lat, rd, er, wc);
        n_tests++;
        if (lat !== 2 || rd !== 8'hA5) begin
            n_fail++;
            $display("FAIL lat1_read: lat=%0d rdata=%h want 2 a5", lat, rd);
        end
        issue(2, 1'b1, 16'hFFFF, 8'h77, lat, rd, er, wc);
        n_tests++;
        if (lat !== 2 || er !== 1'b0 || wc !== 1) begin
            n_fail++;
            $display("FAIL lat1_write: lat=%0d err=%b wren_cycles=%0d want 2 0 1", lat, er, wc);
        end
        issue(1, 1'b0, 16'hFFFF, 8'h00, lat, rd, er, wc);
        n_tests++;
        if (lat !== 3 || rd !== 8'h77) begin
            n_fail++;
            $display("FAIL verify_build_read: lat=%0d rdata=%h want 3 77", lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_verify();
        test_back_to_back();
        test_boundaries();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
